// File: rtl/lbm_position_tracker.sv
// Grid-position / time bookkeeping for the LBM controller: cell and time counters,
// registered boundary flags and D2Q9 streaming addresses. Optional macro: PERIODIC_X_EN.
module lbm_position_tracker #(
  parameter int NX               = 16,
  parameter int NY               = 16,
  parameter int GRID_DIM         = NX * NY,
  parameter int ADDRESS_WIDTH    = $clog2(GRID_DIM),
  parameter int ADDRESS_WIDTH2   = $clog2(GRID_DIM) + 1,
  parameter int MAX_TIME         = 10,
  parameter int TIME_COUNT_WIDTH = $clog2(MAX_TIME)
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        count_init_en,
  input  logic                        row_count_en,
  input  logic                        time_count_en,
  output logic [ADDRESS_WIDTH-1:0]    count_init,
  output logic [TIME_COUNT_WIDTH-1:0] time_count,
  output logic [$clog2(NY)-1:0]       row,
  output logic [$clog2(NX)-1:0]       col,
  output logic                        LID,
  output logic                        BOTTOM_WALL,
  output logic                        LEFT_WALL,
  output logic                        RIGHT_WALL,
  output logic [ADDRESS_WIDTH2-1:0]   stream_addr0,
  output logic [ADDRESS_WIDTH2-1:0]   stream_addr1,
  output logic [ADDRESS_WIDTH2-1:0]   stream_addr2,
  output logic [ADDRESS_WIDTH2-1:0]   stream_addr3,
  output logic [ADDRESS_WIDTH2-1:0]   stream_addr4,
  output logic [ADDRESS_WIDTH2-1:0]   stream_addr5,
  output logic [ADDRESS_WIDTH2-1:0]   stream_addr6,
  output logic [ADDRESS_WIDTH2-1:0]   stream_addr7,
  output logic [ADDRESS_WIDTH2-1:0]   stream_addr8,
  output logic                        decode_valid,
  output logic                        sim_done
);

  localparam int AW  = ADDRESS_WIDTH;
  localparam int AW2 = ADDRESS_WIDTH2;
  localparam int RW  = $clog2(NY);
  localparam int CW  = $clog2(NX);
  localparam int TW  = TIME_COUNT_WIDTH;

  // D2Q9 velocity set, direction order 0..8
  localparam int CX [9] = '{0, 1, 0, -1, 0, 1, -1, -1, 1};
  localparam int CY [9] = '{0, 0, 1, 0, -1, 1, 1, -1, -1};

  logic [AW-1:0]  count_q, count_d;
  logic [RW-1:0]  row_cnt_q, row_cnt_d;
  logic [CW-1:0]  col_cnt_q, col_cnt_d;
  logic [TW-1:0]  time_q, time_d;
  logic [RW-1:0]  row_q;
  logic [CW-1:0]  col_q;
  logic           lid_q, bottom_q, left_q, right_q;
  logic           left_d, right_d;
  logic           valid_q;
  logic [AW2-1:0] addr_q [9];
  logic [AW2-1:0] addr_d [9];

  // Neighbour index, or all-ones when the neighbour falls off the grid.
  function automatic logic [AW2-1:0] neigh(input logic [CW-1:0] c, input logic [RW-1:0] r,
                                           input int dx, input int dy);
    int x;
    int y;
    x = int'(c) + dx;
    y = int'(r) + dy;
`ifdef PERIODIC_X_EN
    if (x < 0) x = NX - 1;
    else if (x >= NX) x = 0;
`endif
    if (x < 0 || x >= NX || y < 0 || y >= NY) return '1;
    return AW2'(y * NX + x);
  endfunction

  // Row/col counters run alongside the linear count so no divider is needed.
  always_comb begin
    count_d   = count_q;
    row_cnt_d = row_cnt_q;
    col_cnt_d = col_cnt_q;
    if (count_init_en) begin
      count_d = (count_q == AW'(GRID_DIM - 1)) ? '0 : count_q + 1'b1;
      if (col_cnt_q == CW'(NX - 1)) begin
        col_cnt_d = '0;
        row_cnt_d = (row_cnt_q == RW'(NY - 1)) ? '0 : row_cnt_q + 1'b1;
      end else begin
        col_cnt_d = col_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    time_d = time_q;
    if (time_count_en && time_q != TW'(MAX_TIME)) time_d = time_q + 1'b1;
  end

  always_comb begin
    for (int k = 0; k < 9; k++) addr_d[k] = neigh(col_cnt_q, row_cnt_q, CX[k], CY[k]);
`ifdef PERIODIC_X_EN
    left_d  = 1'b0;
    right_d = 1'b0;
`else
    left_d  = (col_cnt_q == '0);
    right_d = (col_cnt_q == CW'(NX - 1));
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q   <= '0;
      row_cnt_q <= '0;
      col_cnt_q <= '0;
      time_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      lid_q     <= 1'b0;
      bottom_q  <= 1'b0;
      left_q    <= 1'b0;
      right_q   <= 1'b0;
      valid_q   <= 1'b0;
      for (int k = 0; k < 9; k++) addr_q[k] <= '1;
    end else begin
      count_q   <= count_d;
      row_cnt_q <= row_cnt_d;
      col_cnt_q <= col_cnt_d;
      time_q    <= time_d;
      if (row_count_en) begin
        row_q    <= row_cnt_q;
        col_q    <= col_cnt_q;
        lid_q    <= (row_cnt_q == RW'(NY - 1));
        bottom_q <= (row_cnt_q == '0);
        left_q   <= left_d;
        right_q  <= right_d;
        for (int k = 0; k < 9; k++) addr_q[k] <= addr_d[k];
      end
      // Set wins over clear when both enables coincide.
      if (row_count_en)       valid_q <= 1'b1;
      else if (count_init_en) valid_q <= 1'b0;
    end
  end

  assign count_init   = count_q;
  assign time_count   = time_q;
  assign row          = row_q;
  assign col          = col_q;
  assign LID          = lid_q;
  assign BOTTOM_WALL  = bottom_q;
  assign LEFT_WALL    = left_q;
  assign RIGHT_WALL   = right_q;
  assign stream_addr0 = addr_q[0];
  assign stream_addr1 = addr_q[1];
  assign stream_addr2 = addr_q[2];
  assign stream_addr3 = addr_q[3];
  assign stream_addr4 = addr_q[4];
  assign stream_addr5 = addr_q[5];
  assign stream_addr6 = addr_q[6];
  assign stream_addr7 = addr_q[7];
  assign stream_addr8 = addr_q[8];
  assign decode_valid = valid_q;
  assign sim_done     = (time_q == TW'(MAX_TIME));

endmodule

// File: tb/tb_lbm_position_tracker.sv
// Directed bench for lbm_position_tracker (16x16 grid, MAX_TIME=10); honours PERIODIC_X_EN.
module tb_lbm_position_tracker;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       count_init_en, row_count_en, time_count_en;
  logic [7:0] count_init;
  logic [3:0] time_count;
  logic [3:0] row, col;
  logic       LID, BOTTOM_WALL, LEFT_WALL, RIGHT_WALL;
  logic [8:0] sa [9];
  logic       decode_valid, sim_done;

  int n_cmp = 0;
  int n_err = 0;
  int exp_a [9];

  always #5 Clk = ~Clk;

  lbm_position_tracker dut (
    .Clk(Clk), .Reset(Reset),
    .count_init_en(count_init_en), .row_count_en(row_count_en), .time_count_en(time_count_en),
    .count_init(count_init), .time_count(time_count), .row(row), .col(col),
    .LID(LID), .BOTTOM_WALL(BOTTOM_WALL), .LEFT_WALL(LEFT_WALL), .RIGHT_WALL(RIGHT_WALL),
    .stream_addr0(sa[0]), .stream_addr1(sa[1]), .stream_addr2(sa[2]),
    .stream_addr3(sa[3]), .stream_addr4(sa[4]), .stream_addr5(sa[5]),
    .stream_addr6(sa[6]), .stream_addr7(sa[7]), .stream_addr8(sa[8]),
    .decode_valid(decode_valid), .sim_done(sim_done)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_addrs(input string tag);
    for (int k = 0; k < 9; k++) chk($sformatf("%s_addr%0d", tag, k), int'(sa[k]), exp_a[k]);
  endtask

  task automatic chk_flags(input string tag, input int lid, input int bot, input int lft, input int rgt);
    chk({tag, "_lid"},   int'(LID), lid);
    chk({tag, "_bot"},   int'(BOTTOM_WALL), bot);
    chk({tag, "_left"},  int'(LEFT_WALL), lft);
    chk({tag, "_right"}, int'(RIGHT_WALL), rgt);
  endtask

  // Drive enables for one rising edge; outputs are then sampled at the following falling edge.
  task automatic tick(input logic cie, input logic rce, input logic tce);
    count_init_en = cie;
    row_count_en  = rce;
    time_count_en = tce;
    @(negedge Clk);
    count_init_en = 1'b0;
    row_count_en  = 1'b0;
    time_count_en = 1'b0;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset dominates all-high enables
    Reset = 1'b1;
    count_init_en = 1'b1; row_count_en = 1'b1; time_count_en = 1'b1;
    @(negedge Clk);
    tick(1'b1, 1'b1, 1'b1);
    Reset = 1'b0;
    chk("rst_count", int'(count_init), 0);
    chk("rst_time", int'(time_count), 0);
    chk("rst_row", int'(row), 0);
    chk("rst_col", int'(col), 0);
    chk("rst_valid", int'(decode_valid), 0);
    chk("rst_done", int'(sim_done), 0);
    chk_flags("rst", 0, 0, 0, 0);
    exp_a = '{511, 511, 511, 511, 511, 511, 511, 511, 511};
    chk_addrs("rst");

    // Interior cell 17 = (row 1, col 1)
    pulses(17);
    chk("c17_count", int'(count_init), 17);
    chk("c17_valid_pre", int'(decode_valid), 0);
    tick(1'b0, 1'b1, 1'b0);
    chk("c17_row", int'(row), 1);
    chk("c17_col", int'(col), 1);
    chk("c17_valid", int'(decode_valid), 1);
    chk_flags("c17", 0, 0, 0, 0);
    exp_a = '{17, 18, 33, 16, 1, 34, 32, 0, 2};
    chk_addrs("c17");

    // Wrap back to 0 and decode the bottom-left corner
    tick(1'b1, 1'b0, 1'b0);
    chk("c18_count", int'(count_init), 18);
    chk("c18_valid_clr", int'(decode_valid), 0);
    pulses(238);
    chk("wrap_count", int'(count_init), 0);
    tick(1'b0, 1'b1, 1'b0);
    chk("c0_row", int'(row), 0);
    chk("c0_col", int'(col), 0);
`ifdef PERIODIC_X_EN
    chk_flags("c0", 0, 1, 0, 0);
    exp_a = '{0, 1, 16, 15, 511, 17, 31, 511, 511};
`else
    chk_flags("c0", 0, 1, 1, 0);
    exp_a = '{0, 1, 16, 511, 511, 17, 511, 511, 511};
`endif
    chk_addrs("c0");

    // Top-right corner 255
    pulses(255);
    chk("c255_count", int'(count_init), 255);
    tick(1'b0, 1'b1, 1'b0);
    chk("c255_row", int'(row), 15);
    chk("c255_col", int'(col), 15);
`ifdef PERIODIC_X_EN
    chk_flags("c255", 1, 0, 0, 0);
    exp_a = '{255, 240, 511, 254, 239, 511, 511, 238, 224};
`else
    chk_flags("c255", 1, 0, 0, 1);
    exp_a = '{255, 511, 511, 254, 239, 511, 511, 238, 511};
`endif
    chk_addrs("c255");
    tick(1'b1, 1'b0, 1'b0);
    chk("c255_wrap_count", int'(count_init), 0);
    chk("c255_wrap_valid", int'(decode_valid), 0);

    // Time counter saturation
    for (int i = 1; i <= 12; i++) begin
      tick(1'b0, 1'b0, 1'b1);
      chk($sformatf("time_%0d", i), int'(time_count), (i < 10) ? i : 10);
      chk($sformatf("done_%0d", i), int'(sim_done), (i < 10) ? 0 : 1);
    end

    // Simultaneous count advance and decode at index 5, plus time enable (saturated)
    pulses(5);
    tick(1'b1, 1'b1, 1'b1);
    chk("sim_addr0", int'(sa[0]), 5);
    chk("sim_count", int'(count_init), 6);
    chk("sim_valid", int'(decode_valid), 1);
    chk("sim_col", int'(col), 5);
    chk("sim_row", int'(row), 0);
    chk("sim_time", int'(time_count), 10);

    // Mid-operation reset overrides enables
    Reset = 1'b1;
    tick(1'b1, 1'b1, 1'b1);
    Reset = 1'b0;
    chk("mrst_count", int'(count_init), 0);
    chk("mrst_time", int'(time_count), 0);
    chk("mrst_done", int'(sim_done), 0);
    chk("mrst_valid", int'(decode_valid), 0);
    chk("mrst_col", int'(col), 0);
    exp_a = '{511, 511, 511, 511, 511, 511, 511, 511, 511};
    chk_addrs("mrst");

    // Counting resumes from 0 after reset
    tick(1'b1, 1'b0, 1'b1);
    chk("post_count", int'(count_init), 1);
    chk("post_time", int'(time_count), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
